// File: rtl/nubus_pkg.sv
// nubus_pkg: shared NuBus arbitration types and constants
// Ports: none (package)
package nubus_pkg;
    localparam int NUBUS_MIN_ARB_CYCLES = 2;
    typedef enum logic [2:0] {IDLE, WAIT_FAIR, ARB, WAIT_BUS, GRANT, OWN} arb_st_t;
endpackage

// File: rtl/nubus_bus_tracker.sv
// nubus_bus_tracker: tracks whether a NuBus transaction is in flight
// Ports: clk/rst (sync, active high), startn_i/ackn_i sampled START*/ACK*,
//        bus_free_o = no tenure open, or the open one is acknowledging this cycle
module nubus_bus_tracker (
    input  logic clk,
    input  logic rst,
    input  logic startn_i,
    input  logic ackn_i,
    output logic bus_free_o
);
    logic busy_q, busy_d;
    // START with ACK is an attention cycle and leaves the flag alone
    always_comb busy_d = (~ackn_i & startn_i) ? 1'b0 : (ackn_i & ~startn_i) ? 1'b1 : busy_q;
    always_ff @(posedge clk) busy_q <= rst ? 1'b0 : busy_d;
    assign bus_free_o = ~busy_q | ~ackn_i;
endmodule

// File: rtl/nubus_arb_sequencer.sv
// nubus_arb_sequencer: sequences this card's NuBus bus request, arbitration and tenure
// Ports: nub_clkn/nub_reset clock and sync active-high reset; nub_rqstn/nub_startn/nub_ackn
//        sampled bus lines; arb_grant contender result; arbcyn/rqst_oe contender and RQST*
//        drives; mst_req/mst_busy from the local master; mst_grant start pulse, mst_owner tenure
module nubus_arb_sequencer import nubus_pkg::*; #(
    parameter int ARB_CYCLES = NUBUS_MIN_ARB_CYCLES,
    parameter bit FAIR       = 1'b1
) (
    input  logic nub_clkn,
    input  logic nub_reset,
    input  logic nub_rqstn,
    input  logic nub_startn,
    input  logic nub_ackn,
    input  logic arb_grant,
    output logic arbcyn,
    output logic rqst_oe,
    input  logic mst_req,
    output logic mst_grant,
    input  logic mst_busy,
    output logic mst_owner
);
    localparam int CW = $clog2(ARB_CYCLES + 1);
    localparam logic [CW-1:0] ARB_MAX = CW'(ARB_CYCLES);
    arb_st_t state_q, state_d;
    logic [CW-1:0] arb_cnt_q, arb_cnt_d, arb_cnt_inc;
    logic fair_hold_q, fair_hold_d, busy_seen_q, busy_seen_d, bus_free;
    nubus_bus_tracker u_bus (
        .clk       (nub_clkn),
        .rst       (nub_reset),
        .startn_i  (nub_startn),
        .ackn_i    (nub_ackn),
        .bus_free_o(bus_free)
    );
    // the window is judged on the count including the current ARB cycle
    assign arb_cnt_inc = (arb_cnt_q == ARB_MAX) ? arb_cnt_q : arb_cnt_q + CW'(1);
    always_comb begin
        state_d     = state_q;
        arb_cnt_d   = arb_cnt_q;
        fair_hold_d = fair_hold_q;
        busy_seen_d = 1'b0;
        case (state_q)
            IDLE:
                if (mst_req) begin
                    if (FAIR && fair_hold_q && !nub_rqstn) state_d = WAIT_FAIR;
                    else begin
                        state_d     = ARB;
                        arb_cnt_d   = '0;
                        fair_hold_d = 1'b0;
                    end
                end
            WAIT_FAIR:
                if (!mst_req) state_d = IDLE;
                else if (nub_rqstn) begin
                    state_d     = ARB;
                    arb_cnt_d   = '0;
                    fair_hold_d = 1'b0;
                end
            ARB:
                if (!mst_req) state_d = IDLE;
                else if (!nub_startn) arb_cnt_d = '0;
                else if (arb_cnt_inc == ARB_MAX && arb_grant) state_d = WAIT_BUS;
                else arb_cnt_d = arb_cnt_inc;
            WAIT_BUS:
                if (!mst_req) state_d = IDLE;
                else if (!arb_grant) begin
                    state_d   = ARB;
                    arb_cnt_d = '0;
                end else if (bus_free) state_d = GRANT;
            GRANT: state_d = OWN;
            OWN: begin
                busy_seen_d = busy_seen_q | mst_busy;
                if (busy_seen_q && !mst_busy) begin
                    state_d     = IDLE;
                    fair_hold_d = FAIR;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            state_q     <= IDLE;
            arb_cnt_q   <= '0;
            fair_hold_q <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arb_cnt_q   <= arb_cnt_d;
            fair_hold_q <= fair_hold_d;
            busy_seen_q <= busy_seen_d;
        end
    end
    assign rqst_oe   = (state_q == ARB) || (state_q == WAIT_BUS);
    assign arbcyn    = ~rqst_oe;
    assign mst_grant = state_q == GRANT;
    assign mst_owner = mst_grant || (state_q == OWN);
endmodule
